// File: rtl/tone_sequencer.sv
// Note-queue controller for the LUT sine generator: FIFO'd (step, dur) commands play as LOAD -> PLAY -> optional GAP.
// First LOAD one cycle after a command lands in an empty FIFO; cmd_ready drops only when the FIFO is full.

module tone_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head_dat,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full     = (r_level == FULL_LVL);
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

module tone_sequencer #(
    parameter int PERIOD_W   = 16,
    parameter int DUR_W      = 16,
    parameter int TICK_DIV   = 1000,
    parameter int GAP_TICKS  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [PERIOD_W-1:0]         cmd_step,
    input  logic [DUR_W-1:0]            cmd_dur,
    input  logic                        abort,
    output logic                        sin_clk,
    output logic                        sine_reset,
    output logic                        mute,
    output logic                        note_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    typedef struct packed {
        logic [PERIOD_W-1:0] step;
        logic [DUR_W-1:0]    dur;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_CYC = (GAP_TICKS > 0) ? GAP_TICKS * TICK_DIV : 1;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

    state_t              r_state;
    state_t              w_next;
    cmd_t                w_cmd_in;
    cmd_t                w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic [PERIOD_W-1:0] r_step;
    logic [DUR_W-1:0]    r_dur;
    logic [PERIOD_W-1:0] r_step_ctr;
    logic [TICK_W-1:0]   r_tick_ctr;
    logic [GAP_W-1:0]    r_gap_ctr;
    logic                w_step_hit;
    logic                w_tick_wrap;
    logic                w_last;
    logic                w_gap_end;

    assign w_cmd_in    = {cmd_step, cmd_dur};
    assign cmd_ready   = !w_full;
    assign w_pop       = (r_state == S_LOAD) && !abort;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign w_step_hit  = (r_step != '0) && (r_step_ctr == r_step - 1'b1);
    assign w_tick_wrap = (r_tick_ctr == TICK_LAST);
    assign w_last      = w_tick_wrap && (r_dur == DUR_W'(1));
    assign w_gap_end   = (r_gap_ctr == GAP_LAST);

    tone_fifo #(.W($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (abort),
        .i_push     (cmd_valid && !abort),
        .i_push_dat (w_cmd_in),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // abort overrides everything: no strobes, no note_done, straight to IDLE
    always_comb begin
        w_next     = r_state;
        sin_clk    = 1'b0;
        sine_reset = 1'b0;
        note_done  = 1'b0;
        mute       = 1'b1;
        unique case (r_state)
            S_IDLE: if (!w_empty) w_next = S_LOAD;
            S_LOAD: begin
                sine_reset = !abort;
                w_next     = S_PLAY;
            end
            S_PLAY: begin
                sin_clk   = w_step_hit && !abort;
                note_done = w_last && !abort;
                mute      = (r_step == '0);
                if (w_last) begin
                    if (GAP_TICKS > 0) w_next = S_GAP;
                    else               w_next = w_empty ? S_IDLE : S_LOAD;
                end
            end
            S_GAP: if (w_gap_end) w_next = w_empty ? S_IDLE : S_LOAD;
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step     <= '0;
            r_dur      <= '0;
            r_step_ctr <= '0;
            r_tick_ctr <= '0;
            r_gap_ctr  <= '0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    r_step     <= w_head.step;
                    r_dur      <= (w_head.dur == '0) ? DUR_W'(1) : w_head.dur;
                    r_step_ctr <= '0;
                    r_tick_ctr <= '0;
                end
                S_PLAY: begin
                    if (w_step_hit)          r_step_ctr <= '0;
                    else if (r_step != '0)   r_step_ctr <= r_step_ctr + 1'b1;
                    if (w_tick_wrap) begin
                        r_tick_ctr <= '0;
                        r_dur      <= r_dur - 1'b1;
                    end else begin
                        r_tick_ctr <= r_tick_ctr + 1'b1;
                    end
                    r_gap_ctr <= '0;
                end
                S_GAP:   r_gap_ctr <= r_gap_ctr + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer with TICK_DIV=4, GAP_TICKS=2, FIFO_DEPTH=4; notes are scored against an expected-note queue.
module tb_tone_sequencer;
    localparam int PW      = 16;
    localparam int DW      = 16;
    localparam int TD      = 4;
    localparam int GT      = 2;
    localparam int FD      = 4;
    localparam int GAP_CYC = GT * TD;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [PW-1:0] cmd_step;
    logic [DW-1:0] cmd_dur;
    logic          abort;
    logic          sin_clk;
    logic          sine_reset;
    logic          mute;
    logic          note_done;
    logic          busy;
    logic [2:0]    fifo_level;

    typedef struct {
        int step;
        int dur;
        int cycles;
        int pulses;
        int first;
        int mute_lo;
    } note_t;

    note_t sb[$];
    note_t tbl[6];
    note_t m_exp;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;
    int    n_loads  = 0;
    int    n_done   = 0;
    bit    in_note  = 0;
    int    m_cyc, m_pulses, m_first, m_mute_lo;
    int    bs[6] = '{2, 3, 1, 0, 4, 5};
    int    bd[6] = '{100, 1, 2, 1, 2, 3};
    int    w, gap_bad, stray, base_loads, base_done;

    always #5 clk = ~clk;

    tone_sequencer #(
        .PERIOD_W(PW), .DUR_W(DW), .TICK_DIV(TD), .GAP_TICKS(GT), .FIFO_DEPTH(FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_step   (cmd_step),
        .cmd_dur    (cmd_dur),
        .abort      (abort),
        .sin_clk    (sin_clk),
        .sine_reset (sine_reset),
        .mute       (mute),
        .note_done  (note_done),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic note_t model(int step, int dur);
        note_t n;
        int d;
        d         = (dur == 0) ? 1 : dur;
        n.step    = step;
        n.dur     = dur;
        n.cycles  = d * TD;
        n.pulses  = (step == 0) ? 0 : n.cycles / step;
        n.first   = (step == 0 || step > n.cycles) ? 0 : step;
        n.mute_lo = (step == 0) ? 0 : n.cycles;
        return n;
    endfunction

    // Monitor: a note runs from its sine_reset cycle to its note_done cycle
    always @(negedge clk) begin
        if (reset) begin
            in_note = 0;
            sb.delete();
        end else if (abort) begin
            check("abort_sin_clk", sin_clk, 0);
            check("abort_note_done", note_done, 0);
            check("abort_sine_reset", sine_reset, 0);
            in_note = 0;
            sb.delete();
        end else if (sine_reset) begin
            n_loads++;
            check("load_mute", mute, 1);
            check("load_while_playing", in_note, 0);
            in_note = 1; m_cyc = 0; m_pulses = 0; m_first = 0; m_mute_lo = 0;
        end else if (in_note) begin
            m_cyc++;
            if (sin_clk) begin
                m_pulses++;
                if (m_first == 0) m_first = m_cyc;
            end
            if (!mute) m_mute_lo++;
            if (note_done) begin
                in_note = 0;
                n_done++;
                if (sb.size() == 0) check("note_without_cmd", sb.size(), 1);
                else begin
                    m_exp = sb.pop_front();
                    check($sformatf("note_cycles step=%0d dur=%0d", m_exp.step, m_exp.dur), m_cyc, m_exp.cycles);
                    check($sformatf("note_pulses step=%0d dur=%0d", m_exp.step, m_exp.dur), m_pulses, m_exp.pulses);
                    check($sformatf("note_first_pulse step=%0d dur=%0d", m_exp.step, m_exp.dur), m_first, m_exp.first);
                    check($sformatf("note_unmuted step=%0d dur=%0d", m_exp.step, m_exp.dur), m_mute_lo, m_exp.mute_lo);
                end
            end
        end else begin
            if (sin_clk || note_done) check("strobe_outside_note", int'(sin_clk) + int'(note_done), 0);
            if (!mute) check("mute_outside_note", mute, 1);
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Call only right after align() or a previous push_cmd
    task automatic push_cmd(input int step, input int dur, input note_t exp_n, output int waited);
        bit acc;
        acc       = 0;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_step  = step[PW-1:0];
        cmd_dur   = dur[DW-1:0];
        while (!acc && waited < 2000) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        cmd_valid = 1'b0;
        if (acc) sb.push_back(exp_n);
        check($sformatf("push_accepted step=%0d", step), int'(acc), 1);
    endtask

    task automatic wait_note_done(input int limit, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!note_done && k < limit);
        check(name, int'(note_done), 1);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < limit);
        check(name, int'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sin_clk"}, sin_clk, 0);
        check({tag, "_sine_reset"}, sine_reset, 0);
        check({tag, "_note_done"}, note_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mute"}, mute, 1);
        check({tag, "_fifo_level"}, fifo_level, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3, 2, 8, 2, 3, 8};
        tbl[1] = '{0, 1, 4, 0, 0, 0};
        tbl[2] = '{1, 0, 4, 4, 1, 4};
        tbl[3] = '{5, 3, 12, 2, 5, 12};
        tbl[4] = '{7, 1, 4, 0, 0, 4};
        tbl[5] = '{2, 5, 20, 10, 2, 20};

        reset = 1'b1; cmd_valid = 1'b0; cmd_step = '0; cmd_dur = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        align();
        reset = 1'b0;

        // Single notes from IDLE: latency, play phase, gap, return to IDLE
        for (int i = 0; i < 6; i++) begin
            align();
            push_cmd(tbl[i].step, tbl[i].dur, tbl[i], w);
            @(negedge clk);
            check($sformatf("tbl%0d_no_load_yet", i), sine_reset, 0);
            check($sformatf("tbl%0d_level_one", i), fifo_level, 1);
            @(negedge clk);
            check($sformatf("tbl%0d_load_pulse", i), sine_reset, 1);
            wait_note_done(200, $sformatf("tbl%0d_note_done_seen", i));
            gap_bad = 0;
            for (int g = 0; g < GAP_CYC; g++) begin
                @(negedge clk);
                if (!mute || sin_clk || sine_reset || note_done || !busy) gap_bad++;
            end
            check($sformatf("tbl%0d_gap_quiet", i), gap_bad, 0);
            @(negedge clk);
            check($sformatf("tbl%0d_idle_busy", i), busy, 0);
            check($sformatf("tbl%0d_sb_drained", i), sb.size(), 0);
        end

        // Back-to-back commands behind a long note: FIFO fills, 6th stalls until the next LOAD
        base_loads = n_loads;
        base_done  = n_done;
        align();
        for (int i = 0; i < 5; i++) push_cmd(bs[i], bd[i], model(bs[i], bd[i]), w);
        @(negedge clk);
        check("b2b_level_full", fifo_level, 4);
        check("b2b_ready_low", cmd_ready, 0);
        align();
        push_cmd(bs[5], bd[5], model(bs[5], bd[5]), w);
        check("b2b_c6_accepted_after_load2", n_loads - base_loads, 2);
        wait_idle(3000, "b2b_idle");
        check("b2b_notes_done", n_done - base_done, 6);
        check("b2b_loads", n_loads - base_loads, 6);
        check("b2b_sb_drained", sb.size(), 0);

        // Abort in PLAY cycle 5 (a sin_clk cycle for step=5) with 2 commands queued
        base_done = n_done;
        base_loads = n_loads;
        align();
        push_cmd(5, 4, model(5, 4), w);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!sine_reset && w < 50);
        check("abort_load_seen", sine_reset, 1);
        align();
        push_cmd(2, 2, model(2, 2), w);
        push_cmd(1, 1, model(1, 1), w);
        @(posedge clk);
        @(posedge clk);
        #1;
        abort = 1'b1; cmd_valid = 1'b1; cmd_step = 16'd3; cmd_dur = 16'd1;
        @(negedge clk);
        check("abort_level_before", fifo_level, 2);
        align();
        abort = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_after_level", fifo_level, 0);
        check("abort_after_mute", mute, 1);
        check("abort_after_busy", busy, 0);
        check("abort_after_ready", cmd_ready, 1);
        stray = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (sin_clk || sine_reset || note_done) stray++;
        end
        check("abort_quiet_after", stray, 0);
        check("abort_no_note_done", n_done - base_done, 0);
        check("abort_single_load", n_loads - base_loads, 1);

        // Asynchronous reset in the middle of a note with commands queued
        align();
        push_cmd(2, 50, model(2, 50), w);
        push_cmd(1, 1, model(1, 1), w);
        push_cmd(3, 3, model(3, 3), w);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("prereset_level", fifo_level, 2);
        check("prereset_busy", busy, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        align();
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sin_clk || sine_reset || note_done || busy) stray++;
        end
        check("post_reset_idle", stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Controller that plays a queue of notes on the 8-bit LUT sine generator.
- Accepts note commands (step period, duration) over a valid/ready interface into a small FIFO.
- Per note: pulses the generator's phase reset, then issues step strobes at the programmed rate for the programmed duration, followed by an optional silent gap.
- Sits between the command/control logic and the sine generator. Drives the generator's step-enable and reset inputs, plus a mute flag for the output stage.

Parameters:
- PERIOD_W, 16, width of cmd_step: clk cycles between sine LUT steps.
- DUR_W, 16, width of cmd_dur: note duration in ticks.
- TICK_DIV, 1000, clk cycles per duration tick; must be >= 1.
- GAP_TICKS, 0, silent ticks inserted after every note; 0 means no gap.
- FIFO_DEPTH, 4, command FIFO depth; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_step  in  PERIOD_W  step period; 0 means rest (silent note).
- cmd_dur  in  DUR_W  duration in ticks; 0 is treated as 1.
- abort  in  1  synchronous flush-and-stop.
- sin_clk  out  1  one-cycle step strobe to the sine generator.
- sine_reset  out  1  one-cycle phase-reset pulse to the sine generator.
- mute  out  1  high when no tone is playing.
- note_done  out  1  one-cycle pulse in the last cycle of each note's play phase.
- busy  out  1  high when state != IDLE or the FIFO is non-empty.
- fifo_level  out  clog2(FIFO_DEPTH)+1  number of queued commands.

Behaviour:
- Reset (async): state IDLE, FIFO empty, all counters 0.
  - Outputs: sin_clk=0, sine_reset=0, note_done=0, busy=0, mute=1, fifo_level=0, cmd_ready=1.
  - The top level ORs global reset into the sine generator's reset; this block does not.
- FIFO:
  - Push on cmd_valid && cmd_ready. When full, cmd_ready=0 and no push, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - The new level is visible the cycle after the edge.
- FSM (registered state; outputs are decoded from registers):
  - IDLE: mute=1. If FIFO non-empty, go to LOAD on the next edge.
  - LOAD (exactly 1 cycle):
    - sine_reset=1 and mute=1.
    - Pop the FIFO head into step_r and dur_r, with dur_r = max(cmd_dur, 1).
    - Clear step_ctr and tick_ctr. Go to PLAY.
  - PLAY:
    - step_ctr increments each cycle.
    - sin_clk = (step_r != 0) && (step_ctr == step_r-1). On that cycle step_ctr wraps to 0.
    - tick_ctr counts 0..TICK_DIV-1. On wrap, dur_r decrements.
    - note_done = tick wrap && dur_r == 1. This is the last PLAY cycle.
    - PLAY therefore lasts exactly dur*TICK_DIV cycles and produces floor(dur*TICK_DIV/step) sin_clk pulses.
    - mute = (step_r == 0).
    - Exit: if GAP_TICKS > 0, go to GAP. Otherwise go to LOAD if FIFO non-empty (as seen that cycle), else IDLE.
  - GAP:
    - mute=1, no sin_clk.
    - Lasts GAP_TICKS*TICK_DIV cycles.
    - Then go to LOAD if FIFO non-empty, else IDLE.
- Latency: command accepted at edge N into an empty FIFO in IDLE gives LOAD in cycle N+1..N+2 and first PLAY cycle N+2..N+3. The first sin_clk occurs in PLAY cycle number step_r.
- abort (highest priority, synchronous):
  - Next state IDLE, FIFO flushed (fifo_level=0 next cycle).
  - A push in the same cycle is discarded.
  - No note_done and no sine_reset are generated.
  - sin_clk is forced 0 in the abort cycle; mute=1 from the next cycle.
- Counters: all widths are sized to never overflow. step_ctr wraps only via the sin_clk condition.
- busy is combinational from state and FIFO empty.

Test Plan (TICK_DIV=4, GAP_TICKS=2, FIFO_DEPTH=4):
- Reset pulse mid-operation -> all outputs at reset values immediately (async); fifo_level=0, cmd_ready=1, mute=1.
- Push step=3 dur=2 from IDLE -> LOAD occurs 1 cycle after acceptance.
  - sine_reset pulses once.
  - 8 PLAY cycles with mute=0 and sin_clk in PLAY cycles 3 and 6 (2 pulses).
  - note_done in PLAY cycle 8.
  - 8 GAP cycles with mute=1, then IDLE with busy=0.
- Push step=0 dur=1 -> 4 PLAY cycles, mute=1 throughout, zero sin_clk, one note_done.
- Push step=1 dur=0 -> dur treated as 1: 4 PLAY cycles, 4 sin_clk pulses.
- Push 6 commands back-to-back with a long first note (dur=100):
  - fifo_level reaches 4 and cmd_ready=0.
  - The 6th command stalls until the next LOAD pops.
  - All notes play in order, each preceded by exactly one sine_reset pulse.
- With 2 commands queued, assert abort in PLAY cycle 5 -> next cycle state IDLE, fifo_level=0, mute=1, busy=0; no note_done, no further sin_clk or sine_reset.
